data_mem_lat: RTL and testbench

- Parametrised successor of the single-cycle data memory for the pipelined CPU.
- Word-organised RAM behind a request/response handshake with a configurable access latency.
- Supports word, half and byte stores, and signed/unsigned half and byte loads.
- Detects misaligned, out-of-range and illegal-op accesses and reports them as errors instead of corrupting memory. Sits between the MEM stage and the stall controller.

---
 rtl/dm_pkg.sv | 45 ++++
 rtl/dm_lane_align.sv | 51 +++++
 rtl/data_mem_lat.sv | 164 ++++++++++++++++
 tb/tb_data_mem_lat.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types for the latency data memory: access op codes, FSM states,
// the latched request payload and load-extension helpers.
package dm_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    DM_W  = 3'd0,
    DM_H  = 3'd1,
    DM_HU = 3'd2,
    DM_B  = 3'd3,
    DM_BU = 3'd4
  } dm_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic            we;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } dm_req_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] v);
    return {24'h000000, v};
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: merges store data into the old word and extracts/extends
// the addressed lane for loads.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [XLEN-1:0] i_old_word,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [OP_W-1:0] i_op,
  input  logic [1:0]      i_byte_off,
  output logic [XLEN-1:0] o_store_word_c,
  output logic [XLEN-1:0] o_load_val_c
);

  logic [4:0]      w_bsh;
  logic [4:0]      w_hsh;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_bmask;
  logic [XLEN-1:0] w_hmask;

  assign w_bsh   = {i_byte_off, 3'b000};
  assign w_hsh   = {i_byte_off[1], 4'b0000};
  assign w_byte  = 8'(i_old_word >> w_bsh);
  assign w_half  = 16'(i_old_word >> w_hsh);
  assign w_bmask = 32'h0000_00FF << w_bsh;
  assign w_hmask = 32'h0000_FFFF << w_hsh;

  always_comb begin
    o_store_word_c = i_old_word;
    o_load_val_c   = '0;
    case (i_op)
      DM_W: begin
        o_store_word_c = i_wdata;
        o_load_val_c   = i_old_word;
      end
      DM_H, DM_HU: begin
        o_store_word_c = (i_old_word & ~w_hmask) | ({16'h0000, i_wdata[15:0]} << w_hsh);
        o_load_val_c   = (i_op == DM_H) ? sext16(w_half) : zext16(w_half);
      end
      DM_B, DM_BU: begin
        o_store_word_c = (i_old_word & ~w_bmask) | ({24'h000000, i_wdata[7:0]} << w_bsh);
        o_load_val_c   = (i_op == DM_B) ? sext8(w_byte) : zext8(w_byte);
      end
      default: begin
        o_store_word_c = i_old_word;
        o_load_val_c   = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_lat.sv
// Word-organised data memory with req/ready handshake and fixed access latency.
// Optional store tracing is enabled with macro DM_TRACE_EN.
module data_mem_lat
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            ready,
  input  logic            we,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] pc,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  dm_state_e             r_state;
  dm_state_e             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  dm_req_t               r_req;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_err;
  logic [XLEN-1:0]       r_rdata;
  logic [XLEN-1:0]       r_mem [DEPTH];
  logic                  w_ready_nxt;
  logic                  w_done_nxt;
  logic                  w_accept;
  logic                  w_commit;
  logic                  w_bad;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [XLEN-1:0]       w_old_word;
  logic [XLEN-1:0]       w_store_word;
  logic [XLEN-1:0]       w_load_val;

  assign w_accept   = (r_state == IDLE) && req;
  assign w_commit   = (r_state == BUSY) && (r_cnt == '0);
  assign w_idx      = r_req.addr[DEPTH_LOG2+1:2];
  assign w_old_word = r_mem[w_idx];

  // State register, plus registered copies of the state-decoded outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      IDLE:    w_ready_nxt = 1'b1;
      DONE:    w_done_nxt  = 1'b1;
      default: w_ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_req.we    <= we;
      r_req.op    <= op;
      r_req.addr  <= addr;
      r_req.wdata <= wdata;
      r_cnt       <= CNT_W'(LATENCY - 1);
    end else if ((r_state == BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Rejection rules applied to the latched request
  always_comb begin
    w_bad = 1'b0;
    case (r_req.op)
      DM_W:        w_bad = (r_req.addr[1:0] != 2'b00);
      DM_H, DM_HU: w_bad = r_req.addr[0];
      DM_B, DM_BU: w_bad = 1'b0;
      default:     w_bad = 1'b1;
    endcase
    if (r_req.addr[XLEN-1:DEPTH_LOG2+2] != '0) w_bad = 1'b1;
    if (r_req.we && ((r_req.op == DM_HU) || (r_req.op == DM_BU))) w_bad = 1'b1;
  end

  dm_lane_align u_lane (
    .i_old_word     (w_old_word),
    .i_wdata        (r_req.wdata),
    .i_op           (r_req.op),
    .i_byte_off     (r_req.addr[1:0]),
    .o_store_word_c (w_store_word),
    .o_load_val_c   (w_load_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_commit && r_req.we && !w_bad) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

  // Response registers: err only accompanies done; stores leave rdata alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_commit && w_bad;
      if (w_commit) begin
        if (w_bad)          r_rdata <= '0;
        else if (!r_req.we) r_rdata <= w_load_val;
      end
    end
  end

`ifdef DM_TRACE_EN
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset)         r_pc <= '0;
    else if (w_accept) r_pc <= pc;
  end

  always_ff @(posedge clk) begin
    if (!reset && w_commit && r_req.we && !w_bad)
      $display("@%08h: *%08h <= %08h", r_pc, r_req.addr, r_req.wdata);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
`endif

  assign ready = r_ready;
  assign done  = r_done;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_lat.sv
// Self-checking bench for data_mem_lat: directed plus random accesses against a
// byte-array reference model; second instance exercises back-to-back requests.
module tb_data_mem_lat;

  localparam int unsigned LAT_A     = 3;
  localparam int unsigned LAT_B     = 1;
  localparam int unsigned MEM_BYTES = 4096;

  logic        clk;
  logic        reset;
  logic        req, ready, we, done, err;
  logic [2:0]  op;
  logic [31:0] addr, wdata, pc, rdata;
  logic        req1, ready1, we1, done1, err1;
  logic [2:0]  op1;
  logic [31:0] addr1, wdata1, pc1, rdata1;

  int          n_checks;
  int          n_errors;
  logic [7:0]  mem_b [MEM_BYTES];
  logic [31:0] exp_rd;

  data_mem_lat #(.DEPTH_LOG2(10), .LATENCY(LAT_A)) u_dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready), .we(we), .op(op),
    .addr(addr), .wdata(wdata), .pc(pc), .done(done), .rdata(rdata), .err(err)
  );

  data_mem_lat #(.DEPTH_LOG2(10), .LATENCY(LAT_B)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .ready(ready1), .we(we1), .op(op1),
    .addr(addr1), .wdata(wdata1), .pc(pc1), .done(done1), .rdata(rdata1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference: sizes/alignment/range rules on a flat byte array
  task automatic model(input logic w, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d);
    int sz;
    logic bad;
    logic [31:0] v;
    case (o)
      3'd0:       sz = 4;
      3'd1, 3'd2: sz = 2;
      3'd3, 3'd4: sz = 1;
      default:    sz = 0;
    endcase
    bad = (sz == 0) || (a >= MEM_BYTES) || (w && (o == 3'd2 || o == 3'd4));
    if (!bad && (a % 32'(sz)) != 0) bad = 1'b1;
    if (bad) begin
      exp_rd = 32'h0;
    end else if (w) begin
      for (int k = 0; k < sz; k++) mem_b[int'(a) + k] = d[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < sz; k++) v[8*k +: 8] = mem_b[int'(a) + k];
      if (o == 3'd1) v = {{16{v[15]}}, v[15:0]};
      if (o == 3'd3) v = {{24{v[7]}}, v[7:0]};
      exp_rd = v;
    end
  endtask

  function automatic logic exp_bad(input logic w, input logic [2:0] o, input logic [31:0] a);
    int sz;
    case (o)
      3'd0:       sz = 4;
      3'd1, 3'd2: sz = 2;
      3'd3, 3'd4: sz = 1;
      default:    sz = 0;
    endcase
    if (sz == 0) return 1'b1;
    return (a >= MEM_BYTES) || (w && (o == 3'd2 || o == 3'd4)) || ((a % 32'(sz)) != 0);
  endfunction

  // One access on the LATENCY=3 instance with cycle-by-cycle handshake checks
  task automatic access(input logic w, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    logic e;
    e = exp_bad(w, o, a);
    model(w, o, a, d);
    @(negedge clk);
    we = w; op = o; addr = a; wdata = d; pc = pc + 32'd4; req = 1'b1;
    for (int s = 0; s <= int'(LAT_A) + 1; s++) begin
      @(negedge clk);
      req = 1'b0;
      if (s < int'(LAT_A)) begin
        chk({tag, " busy"}, 32'({ready, done, err}), 32'(3'b000));
      end else if (s == int'(LAT_A)) begin
        chk({tag, " done"}, 32'({ready, done, err}), 32'({1'b0, 1'b1, e}));
        chk({tag, " rdata"}, rdata, exp_rd);
      end else begin
        chk({tag, " idle"}, 32'({ready, done, err}), 32'(3'b100));
        chk({tag, " hold"}, rdata, exp_rd);
      end
    end
  endtask

  initial begin
    int free_at, acc_edge, n_acc, n_done;
    logic xr, xd, rw;
    logic [2:0] ro;
    logic [31:0] ra;
    n_checks = 0; n_errors = 0; exp_rd = 32'h0;
    for (int i = 0; i < int'(MEM_BYTES); i++) mem_b[i] = 8'h00;
    reset = 1'b1;
    req = 0; we = 0; op = 0; addr = 0; wdata = 0; pc = 32'h0000_1000;
    req1 = 0; we1 = 0; op1 = 0; addr1 = 0; wdata1 = 0; pc1 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset ctl", 32'({ready, done, err}), 32'(3'b100));
    chk("reset rdata", rdata, 32'h0);
    chk("reset ctl b", 32'({ready1, done1, err1}), 32'(3'b100));

    access(1, 3'd0, 32'h10, 32'h1234_5678, "st W");
    access(0, 3'd0, 32'h10, 32'h0, "ld W");
    chk("ld W const", rdata, 32'h1234_5678);
    access(1, 3'd3, 32'h11, 32'h0000_00AB, "st B");
    access(0, 3'd0, 32'h10, 32'h0, "ld W after B");
    chk("merge B const", rdata, 32'h1234_AB78);
    access(0, 3'd3, 32'h11, 32'h0, "ld B");
    access(0, 3'd4, 32'h11, 32'h0, "ld BU");
    access(1, 3'd1, 32'h12, 32'h0000_8001, "st H");
    access(0, 3'd1, 32'h12, 32'h0, "ld H");
    chk("ld H const", rdata, 32'hFFFF_8001);
    access(0, 3'd2, 32'h12, 32'h0, "ld HU");
    access(0, 3'd0, 32'h10, 32'h0, "ld W after H");
    chk("merge H const", rdata, 32'h8001_AB78);

    access(0, 3'd0, 32'h13, 32'h0, "bad misalign W");
    access(1, 3'd1, 32'h11, 32'hFFFF_FFFF, "bad misalign H");
    access(0, 3'd7, 32'h10, 32'h0, "bad op");
    access(0, 3'd0, 32'h1000, 32'h0, "bad range");
    access(1, 3'd4, 32'h10, 32'h0, "bad store BU");
    access(1, 3'd0, 32'h0FFC, 32'hCAFE_F00D, "st top word");
    access(0, 3'd3, 32'h0FFF, 32'h0, "ld top byte");
    access(0, 3'd0, 32'h10, 32'h0, "ld W unchanged");

    // Back-to-back: req held high on the LATENCY=1 instance
    @(negedge clk);
    req1 = 1'b1;
    free_at = 0; acc_edge = -100; n_acc = 0; n_done = 0;
    for (int e = 0; e < 12; e++) begin
      if (e >= free_at) begin
        acc_edge = e; free_at = e + int'(LAT_B) + 2; n_acc++;
      end
      @(negedge clk);
      xd = (e == acc_edge + int'(LAT_B));
      xr = (e + 1 >= free_at);
      chk("hold ctl", 32'({ready1, done1, err1}), 32'({xr, xd, 1'b0}));
      if (done1) n_done++;
    end
    req1 = 1'b0;
    chk("hold done count", 32'(n_done), 32'(n_acc));

    for (int t = 0; t < 60; t++) begin
      rw = 1'($urandom_range(0, 1));
      ro = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      ra = ($urandom_range(0, 7) == 0) ? (32'h0FFC + 32'($urandom_range(0, 7)))
                                       : 32'($urandom_range(0, 63));
      access(rw, ro, ra, $urandom, "rand");
    end

    // Reset while the store is in BUSY aborts it and clears the memory
    @(negedge clk);
    we = 1'b1; op = 3'd0; addr = 32'h20; wdata = 32'hDEAD_BEEF; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("abort busy", 32'({ready, done, err}), 32'(3'b000));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort rst ctl", 32'({ready, done, err}), 32'(3'b100));
    chk("abort rst rdata", rdata, 32'h0);
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort no done", 32'(n_done), 32'h0);
    for (int i = 0; i < int'(MEM_BYTES); i++) mem_b[i] = 8'h00;
    exp_rd = 32'h0;
    access(0, 3'd0, 32'h20, 32'h0, "ld after abort");
    access(0, 3'd0, 32'h10, 32'h0, "ld cleared");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
